delay_sink: RTL and testbench



---
 rtl/delay_sink.sv | 84 ++++++++
 tb/tb_delay_sink.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sink.sv
// Credit-granting FIFO at the tail of a fixed-latency delay line; credits cover
// tokens in flight plus stored entries, so the unstallable line never overruns.
module delay_sink #(
  parameter int WIDTH    = 16,
  parameter int LATENCY  = 2,
  parameter int CAPACITY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             can_issue,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             err
);

  localparam int AW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int CW = $clog2(CAPACITY + 1);
  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  generate
    if ((CAPACITY < LATENCY + 2) || ((CAPACITY & (CAPACITY - 1)) != 0)) begin : g_bad_params
      $error("delay_sink: CAPACITY must be a power of two and >= LATENCY+2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [CAPACITY];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_reserved;
  logic             r_err;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_take;
  logic w_viol;

  always_comb begin
    w_full    = (r_count == CAP);
    can_issue = (r_reserved < CAP);
    out_valid = (r_count != '0);
    out_data  = r_mem[r_rd];
    w_push    = in_valid && !w_full;
    w_pop     = out_valid && out_ready;
    w_take    = issue && can_issue;
    w_viol    = (issue && !can_issue) || (in_valid && w_full);
    err       = r_err;
  end

  // Storage is not reset: contents are only observable through out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_reserved <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_reserved <= r_reserved + CW'(w_take) - CW'(w_pop);
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_sink.sv
// Bench for delay_sink: delay line modelled behaviourally, queue-based reference
// model checked every cycle, plus fixed vector table and directed sequences.
module tb_delay_sink;

  localparam int LAT = 2;
  localparam int CAP = 4;

  logic        clk;
  logic        rst;
  logic        issue;
  logic        can_issue;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        err;

  delay_sink #(.WIDTH(16), .LATENCY(LAT), .CAPACITY(CAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .can_issue (can_issue),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  // Reference model: stored tokens, credits in use, sticky error
  logic [15:0] q[$];
  int          resv;
  bit          m_err;
  bit          dl_v [LAT];
  logic [15:0] dl_d [LAT];
  logic [15:0] rx[$];
  int          rxt[$];

  typedef struct {
    bit          iss;
    logic [15:0] d;
    bit          rdy;
    bit          ov;
    logic [15:0] od;
    bit          ci;
    bit          er;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic check_state();
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("can_issue", {31'b0, can_issue}, {31'b0, resv < CAP});
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (q.size() != 0) chk("out_data", {16'b0, out_data}, {16'b0, q[0]});
  endtask

  task automatic clear_model();
    q.delete();
    resv  = 0;
    m_err = 0;
    for (int i = 0; i < LAT; i++) begin
      dl_v[i] = 0;
      dl_d[i] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 0; issue = 0; out_ready = 0; in_valid = 0; in_data = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1;
    clear_model();
    check_state();
  endtask

  // One clock: present inputs, advance model, then sample 1 ns after the edge.
  task automatic cycle(input bit iss, input logic [15:0] d, input bit rdy,
                       input bit inj, input logic [15:0] inj_d);
    bit can, take, pop, push;
    issue     = iss;
    out_ready = rdy;
    in_valid  = dl_v[LAT-1] | inj;
    in_data   = inj ? inj_d : dl_d[LAT-1];
    can  = (resv < CAP);
    take = iss && can;
    pop  = rdy && (q.size() != 0);
    push = in_valid && (q.size() != CAP);
    if (iss && !can) m_err = 1;
    if (in_valid && q.size() == CAP) m_err = 1;
    if (pop) begin
      rx.push_back(q.pop_front());
      rxt.push_back(cyc_n);
    end
    if (push) q.push_back(in_data);
    resv = resv + int'(take) - int'(pop);
    for (int i = LAT - 1; i > 0; i--) begin
      dl_v[i] = dl_v[i-1];
      dl_d[i] = dl_d[i-1];
    end
    dl_v[0] = take;
    dl_d[0] = d;
    @(posedge clk);
    #1;
    cyc_n++;
    check_state();
  endtask

  initial begin
    int sent;
    int base;
    bit iss;
    bit rdy;
    int bias;

    tbl[0]  = '{1, 16'h0B01, 0, 0, 16'h0000, 1, 0};
    tbl[1]  = '{1, 16'h0B02, 0, 0, 16'h0000, 1, 0};
    tbl[2]  = '{1, 16'h0B03, 0, 1, 16'h0B01, 1, 0};
    tbl[3]  = '{1, 16'h0B04, 0, 1, 16'h0B01, 0, 0};
    tbl[4]  = '{0, 16'h0000, 0, 1, 16'h0B01, 0, 0};
    tbl[5]  = '{0, 16'h0000, 0, 1, 16'h0B01, 0, 0};
    tbl[6]  = '{0, 16'h0000, 0, 1, 16'h0B01, 0, 0};
    tbl[7]  = '{0, 16'h0000, 1, 1, 16'h0B02, 1, 0};
    tbl[8]  = '{1, 16'h0B05, 0, 1, 16'h0B02, 0, 0};
    tbl[9]  = '{1, 16'h0B06, 0, 1, 16'h0B02, 0, 1};
    tbl[10] = '{0, 16'h0000, 1, 1, 16'h0B03, 1, 1};

    clear_model();
    rst = 0; issue = 0; out_ready = 0; in_valid = 0; in_data = '0;

    // Reset and idle
    do_reset(2);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_can_issue", {31'b0, can_issue}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);
    repeat (3) cycle(0, '0, 0, 0, '0);

    // Stall, backpressure, issue violation: fixed vectors
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].iss, tbl[i].d, tbl[i].rdy, 0, '0);
      chk($sformatf("tbl%0d_ov", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
      if (tbl[i].ov) chk($sformatf("tbl%0d_od", i), {16'b0, out_data}, {16'b0, tbl[i].od});
      chk($sformatf("tbl%0d_ci", i), {31'b0, can_issue}, {31'b0, tbl[i].ci});
      chk($sformatf("tbl%0d_err", i), {31'b0, err}, {31'b0, tbl[i].er});
    end

    // Overflow injection while full: 0xDEAD must be dropped
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0C01 + 16'(i), 0, 0, '0);
    repeat (2) cycle(0, '0, 0, 0, '0);
    cycle(0, '0, 0, 1, 16'hDEAD);
    chk("ovf_err", {31'b0, err}, 32'd1);
    chk("ovf_head", {16'b0, out_data}, 32'h0C01);
    rx.delete();
    repeat (6) cycle(0, '0, 1, 0, '0);
    chk("ovf_rx_count", rx.size(), 32'd4);
    for (int i = 0; i < rx.size() && i < 4; i++)
      chk("ovf_rx_data", {16'b0, rx[i]}, {16'b0, 16'h0C01 + 16'(i)});

    // Reset with 3 stored and 1 in flight
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0D01 + 16'(i), 0, 0, '0);
    cycle(0, '0, 0, 0, '0);
    do_reset(1);
    chk("mid_rst_ov", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ci", {31'b0, can_issue}, 32'd1);
    chk("mid_rst_err", {31'b0, err}, 32'd0);

    // Full throughput, 3-cycle latency per token
    rx.delete(); rxt.delete();
    base = cyc_n;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 16'(i + 1), 1, 0, '0);
      chk("thru_can_issue", {31'b0, can_issue}, 32'd1);
    end
    repeat (6) cycle(0, '0, 1, 0, '0);
    chk("thru_count", rx.size(), 32'd20);
    for (int i = 0; i < rx.size() && i < 20; i++) begin
      chk("thru_data", {16'b0, rx[i]}, 32'(i + 1));
      chk("thru_latency", rxt[i] - base, 32'(i + 3));
    end
    chk("thru_err", {31'b0, err}, 32'd0);

    // Wrap with alternating ready
    rx.delete();
    sent = 0;
    for (int c = 0; c < 100; c++) begin
      iss = (sent < 12) && (resv < CAP);
      cycle(iss, 16'hA000 + 16'(sent), c[0] == 1'b0, 0, '0);
      if (iss) sent++;
      if (sent == 12 && q.size() == 0 && !dl_v[0] && !dl_v[LAT-1]) break;
    end
    chk("wrap_count", rx.size(), 32'd12);
    for (int i = 0; i < rx.size() && i < 12; i++)
      chk("wrap_data", {16'b0, rx[i]}, {16'b0, 16'hA000 + 16'(i)});

    // Randomized traffic against the model
    do_reset(1);
    rx.delete();
    sent = 0;
    for (int blk = 0; blk < 6; blk++) begin
      bias = 1 + blk % 4;
      for (int c = 0; c < 400; c++) begin
        iss = (resv < CAP) && ($urandom_range(3) != 0);
        rdy = ($urandom_range(4) < bias);
        cycle(iss, 16'($urandom), rdy, 0, '0);
        if (iss) sent++;
      end
    end
    repeat (10) cycle(0, '0, 1, 0, '0);
    chk("rand_count", rx.size(), sent);
    chk("rand_err", {31'b0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
